// File: rtl/tron_pkg.sv
// Shared encodings for the control path: FSM states, writeback bus selects,
// opcode/ext fields and the decoded instruction class.
package tron_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'b000,
    ST_DECODE = 3'b001,
    ST_EXEC   = 3'b010,
    ST_MEM    = 3'b011,
    ST_WB     = 3'b100
  } state_t;

  localparam logic [2:0] BUS_ALU   = 3'b000;
  localparam logic [2:0] BUS_SHIFT = 3'b001;
  localparam logic [2:0] BUS_IMM   = 3'b010;
  localparam logic [2:0] BUS_MEM   = 3'b011;
  localparam logic [2:0] BUS_PC    = 3'b100;
  localparam logic [2:0] BUS_REGB  = 3'b101;

  localparam logic [3:0] OP_RALU    = 4'b0000;
  localparam logic [3:0] OP_SPECIAL = 4'b0100;
  localparam logic [3:0] OP_SHIFT   = 4'b1000;
  localparam logic [3:0] OP_BCOND   = 4'b1100;
  localparam logic [3:0] OP_MOVI    = 4'b1101;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  typedef enum logic [3:0] {
    CL_NOP,
    CL_ALU,
    CL_SHIFT,
    CL_MOVI,
    CL_LOAD,
    CL_STOR,
    CL_JAL,
    CL_JCOND,
    CL_BCOND
  } cls_t;

  function automatic logic is_mem_class(input cls_t c);
    return (c == CL_LOAD) || (c == CL_STOR);
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Signal bundle between the datapath and the control FSM. The FSM side uses
// the slave modport; the datapath (or bench) drives instr/condTrue/memReady.
interface control_fsm_if;
  logic [15:0] instr;
  logic        condTrue;
  logic        memReady;
  logic [2:0]  busSel;
  logic        irWrite;
  logic        regWrite;
  logic        memWrite;
  logic        pcWrite;
  logic        pcBranch;
  logic        addrSel;
  logic [2:0]  state;

  modport master (
    output instr, condTrue, memReady,
    input  busSel, irWrite, regWrite, memWrite, pcWrite, pcBranch, addrSel, state
  );

  modport slave (
    input  instr, condTrue, memReady,
    output busSel, irWrite, regWrite, memWrite, pcWrite, pcBranch, addrSel, state
  );
endinterface

// File: rtl/instr_decode.sv
// Pure combinational classification of an instruction word into its
// execution class; only opcode and ext fields matter.
module instr_decode
  import tron_pkg::*;
(
  input  logic [15:0] i_instr,
  output cls_t        o_class
);

  logic [3:0] w_op;
  logic [3:0] w_ext;
  logic       w_unused_fields;

  assign w_op            = i_instr[15:12];
  assign w_ext           = i_instr[7:4];
  assign w_unused_fields = ^{i_instr[11:8], i_instr[3:0]};

  always_comb begin
    o_class = CL_ALU;
    case (w_op)
      OP_RALU:  o_class = CL_ALU;
      OP_SHIFT: o_class = CL_SHIFT;
      OP_MOVI:  o_class = CL_MOVI;
      OP_BCOND: o_class = CL_BCOND;
      OP_SPECIAL: begin
        case (w_ext)
          EXT_LOAD:  o_class = CL_LOAD;
          EXT_STOR:  o_class = CL_STOR;
          EXT_JAL:   o_class = CL_JAL;
          EXT_JCOND: o_class = CL_JCOND;
          default:   o_class = CL_NOP;
        endcase
      end
      default:  o_class = CL_ALU;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control FSM: FETCH -> DECODE -> EXEC/MEM -> (WB) -> FETCH.
// Outputs are Moore-style from state and the class latched in DECODE.
module control_fsm
  import tron_pkg::*;
(
  input  logic clk,
  input  logic reset,
  control_fsm_if.slave bus
);

  state_t r_state;
  cls_t   r_class;
  state_t w_next;
  cls_t   w_dec_class;

  instr_decode u_decode (
    .i_instr (bus.instr),
    .o_class (w_dec_class)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_class <= CL_NOP;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) r_class <= w_dec_class;
    end
  end

  always_comb begin
    w_next = ST_FETCH;
    case (r_state)
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: begin
        if (w_dec_class == CL_NOP)          w_next = ST_FETCH;
        else if (is_mem_class(w_dec_class)) w_next = ST_MEM;
        else                                w_next = ST_EXEC;
      end
      ST_EXEC:   w_next = (r_class == CL_JAL) ? ST_WB : ST_FETCH;
      ST_MEM: begin
        if (!bus.memReady)           w_next = ST_MEM;
        else if (r_class == CL_LOAD) w_next = ST_WB;
        else                         w_next = ST_FETCH;
      end
      ST_WB:     w_next = ST_FETCH;
      default:   w_next = ST_FETCH;
    endcase
  end

  // Reset gates the enables directly so they drop without waiting for a clock.
  always_comb begin
    bus.busSel   = BUS_ALU;
    bus.irWrite  = 1'b0;
    bus.regWrite = 1'b0;
    bus.memWrite = 1'b0;
    bus.pcWrite  = 1'b0;
    bus.pcBranch = 1'b0;
    bus.addrSel  = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_FETCH: begin
          bus.irWrite = 1'b1;
          bus.pcWrite = 1'b1;
        end
        ST_EXEC: begin
          case (r_class)
            CL_ALU:   bus.regWrite = 1'b1;
            CL_SHIFT: begin
              bus.busSel   = BUS_SHIFT;
              bus.regWrite = 1'b1;
            end
            CL_MOVI: begin
              bus.busSel   = BUS_IMM;
              bus.regWrite = 1'b1;
            end
            CL_JAL: begin
              bus.busSel   = BUS_PC;
              bus.regWrite = 1'b1;
            end
            CL_JCOND, CL_BCOND: begin
              bus.pcWrite  = bus.condTrue;
              bus.pcBranch = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          bus.addrSel  = 1'b1;
          bus.memWrite = (r_class == CL_STOR);
        end
        ST_WB: begin
          if (r_class == CL_LOAD) begin
            bus.busSel   = BUS_MEM;
            bus.regWrite = 1'b1;
          end else if (r_class == CL_JAL) begin
            bus.pcWrite  = 1'b1;
            bus.pcBranch = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.state = r_state;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: directed instruction scenarios plus randomized
// instruction streams checked cycle-by-cycle against a per-instruction trace.
module tb_control_fsm;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  control_fsm_if bus_if ();

  control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [11:0] exp_q[$];
  bit          mr_q[$];

  typedef enum {K_NOP, K_ALU, K_SHIFT, K_MOVI, K_LOAD, K_STOR, K_JAL, K_BR} kind_t;

  // Expected output vector: {state, busSel, irWrite, regWrite, memWrite, pcWrite, pcBranch, addrSel}
  function automatic logic [11:0] mk(input logic [2:0] st, input logic [2:0] bs,
                                     input logic ir, input logic rw, input logic mw,
                                     input logic pw, input logic pb, input logic as);
    return {st, bs, ir, rw, mw, pw, pb, as};
  endfunction

  function automatic kind_t kind_of(input logic [15:0] w);
    int op;
    int ex;
    op = int'(w[15:12]);
    ex = int'(w[7:4]);
    if (op == 4) begin
      if (ex == 0)       return K_LOAD;
      else if (ex == 4)  return K_STOR;
      else if (ex == 8)  return K_JAL;
      else if (ex == 12) return K_BR;
      else               return K_NOP;
    end
    if (op == 0)  return K_ALU;
    if (op == 8)  return K_SHIFT;
    if (op == 13) return K_MOVI;
    if (op == 12) return K_BR;
    return K_ALU;
  endfunction

  task automatic check(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = {bus_if.state, bus_if.busSel, bus_if.irWrite, bus_if.regWrite,
           bus_if.memWrite, bus_if.pcWrite, bus_if.pcBranch, bus_if.addrSel};
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
    end
  endtask

  // Entered and left at posedge+2 of the cycle in which the instruction is in FETCH.
  task automatic run_instr(input logic [15:0] ins, input bit cond, input int waits,
                           input bit scramble, input string name);
    kind_t k;
    k = kind_of(ins);
    exp_q.delete();
    mr_q.delete();
    exp_q.push_back(mk(3'd0, 3'd0, 1, 0, 0, 1, 0, 0)); mr_q.push_back(1'($urandom_range(0, 1)));
    exp_q.push_back(mk(3'd1, 3'd0, 0, 0, 0, 0, 0, 0)); mr_q.push_back(1'($urandom_range(0, 1)));
    case (k)
      K_NOP: ;
      K_LOAD, K_STOR: begin
        for (int w = 0; w <= waits; w++) begin
          exp_q.push_back(mk(3'd3, 3'd0, 0, 0, (k == K_STOR), 0, 0, 1));
          mr_q.push_back(w == waits);
        end
        if (k == K_LOAD) begin
          exp_q.push_back(mk(3'd4, 3'd3, 0, 1, 0, 0, 0, 0)); mr_q.push_back(1'($urandom_range(0, 1)));
        end
      end
      K_ALU:   begin exp_q.push_back(mk(3'd2, 3'd0, 0, 1, 0, 0, 0, 0)); mr_q.push_back(1'($urandom_range(0, 1))); end
      K_SHIFT: begin exp_q.push_back(mk(3'd2, 3'd1, 0, 1, 0, 0, 0, 0)); mr_q.push_back(1'($urandom_range(0, 1))); end
      K_MOVI:  begin exp_q.push_back(mk(3'd2, 3'd2, 0, 1, 0, 0, 0, 0)); mr_q.push_back(1'($urandom_range(0, 1))); end
      K_BR:    begin exp_q.push_back(mk(3'd2, 3'd0, 0, 0, 0, cond, 1, 0)); mr_q.push_back(1'($urandom_range(0, 1))); end
      K_JAL: begin
        exp_q.push_back(mk(3'd2, 3'd4, 0, 1, 0, 0, 0, 0)); mr_q.push_back(1'($urandom_range(0, 1)));
        exp_q.push_back(mk(3'd4, 3'd0, 0, 0, 0, 1, 1, 0)); mr_q.push_back(1'($urandom_range(0, 1)));
      end
      default: ;
    endcase
    for (int i = 0; i < exp_q.size(); i++) begin
      bus_if.instr    = (i < 2 || !scramble) ? ins : 16'($urandom);
      bus_if.condTrue = (exp_q[i][11:9] == 3'd2) ? cond : 1'($urandom_range(0, 1));
      bus_if.memReady = mr_q[i];
      #1 check($sformatf("%s[%04h] c%0d", name, ins, i), exp_q[i]);
      @(posedge clk); #2;
    end
  endtask

  initial begin
    logic [3:0]  op;
    logic [3:0]  ext;
    logic [15:0] rnd;

    reset           = 1'b1;
    bus_if.instr    = 16'h0000;
    bus_if.condTrue = 1'b1;
    bus_if.memReady = 1'b1;
    #3 check("reset_async", 12'h000);
    @(posedge clk); #2;
    bus_if.instr = 16'h4342;
    #1 check("reset_hold", 12'h000);
    reset = 1'b0;

    run_instr(16'h0152, 1'b0, 0, 1'b0, "r_alu");
    run_instr(16'h4302, 1'b0, 2, 1'b0, "load_w2");
    run_instr(16'hC0FE, 1'b1, 0, 1'b0, "bcond_t");
    run_instr(16'hC0FE, 1'b0, 0, 1'b0, "bcond_f");
    run_instr(16'h4380, 1'b0, 0, 1'b0, "jal");
    run_instr(16'hD105, 1'b0, 0, 1'b1, "movi_scr");
    run_instr(16'h8123, 1'b1, 0, 1'b0, "shift");
    run_instr(16'h40C0, 1'b1, 0, 1'b0, "jcond_t");
    run_instr(16'h4012, 1'b1, 0, 1'b0, "nop");
    run_instr(16'h4342, 1'b0, 0, 1'b0, "stor_w0");
    run_instr(16'h4342, 1'b0, 3, 1'b0, "stor_w3");
    run_instr(16'h7A3C, 1'b0, 0, 1'b0, "i_alu");

    // Reset in the middle of a stalled store.
    bus_if.instr    = 16'h4342;
    bus_if.memReady = 1'b0;
    #1 check("rst_stor_fetch", mk(3'd0, 3'd0, 1, 0, 0, 1, 0, 0));
    @(posedge clk); #2;
    #1 check("rst_stor_decode", mk(3'd1, 3'd0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #2;
    #1 check("rst_stor_mem0", mk(3'd3, 3'd0, 0, 0, 1, 0, 0, 1));
    @(posedge clk); #2;
    #1 check("rst_stor_mem1", mk(3'd3, 3'd0, 0, 0, 1, 0, 0, 1));
    reset = 1'b1;
    #1 check("rst_stor_drop", 12'h000);
    @(posedge clk); #2;
    bus_if.memReady = 1'b1;
    #1 check("rst_stor_held", 12'h000);
    reset = 1'b0;
    run_instr(16'h0152, 1'b0, 0, 1'b0, "after_rst");

    for (int n = 0; n < 80; n++) begin
      op = 4'($urandom);
      case ($urandom_range(0, 4))
        0:       ext = 4'b0000;
        1:       ext = 4'b0100;
        2:       ext = 4'b1000;
        3:       ext = 4'b1100;
        default: ext = 4'($urandom);
      endcase
      if ($urandom_range(0, 2) == 0) op = 4'b0100;
      rnd = {op, 4'($urandom), ext, 4'($urandom)};
      run_instr(rnd, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
